// File: rtl/reg_file_param.sv
// Parameterised register file: two combinational read ports, one write port,
// a per-register pending (scoreboard) bit with reserve/complete, and a global clear.
module reg_file_param #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    SEL_A,
  input  logic [AW-1:0]    SEL_B,
  input  logic             write_en,
  input  logic [AW-1:0]    SEL_W,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             reserve_en,
  input  logic [AW-1:0]    SEL_R,
  input  logic             clear_en,
  output logic [WIDTH-1:0] OUT_A,
  output logic [WIDTH-1:0] OUT_B,
  output logic             PEND_A,
  output logic             PEND_B
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic             w_ok;
  logic             r_ok;
  logic             byp_live;
  logic [AW-1:0]    rd_sel  [2];
  logic [WIDTH-1:0] rd_data [2];
  logic [1:0]       rd_pend;

  // Address names a real, writable register (excludes hard-wired r0).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = ({1'b0, a} < DEPTH_C) && !(ZERO_R0 && (a == '0));
  endfunction

  assign w_ok = write_en && addr_ok(SEL_W);
  assign r_ok = reserve_en && addr_ok(SEL_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else if (clear_en) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else begin
      if (w_ok) begin
        mem[SEL_W]  <= DATA_IN;
        pend[SEL_W] <= 1'b0;
      end
      // Later assignment: a same-cycle reserve leaves the pending bit set.
      if (r_ok) pend[SEL_R] <= 1'b1;
    end
  end

  // Forwarding deliberately ignores clear_en/reserve_en so neither reaches the
  // outputs combinationally; rst_n gates it so reset reads all-zero.
  assign byp_live  = BYPASS && rst_n && w_ok;
  assign rd_sel[0] = SEL_A;
  assign rd_sel[1] = SEL_B;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_pend[p] = 1'b0;
      if (addr_ok(rd_sel[p])) begin
        if (byp_live && (SEL_W == rd_sel[p])) begin
          rd_data[p] = DATA_IN;
        end else begin
          rd_data[p] = mem[rd_sel[p]];
          rd_pend[p] = pend[rd_sel[p]];
        end
      end
    end
  end

  assign OUT_A  = rd_data[0];
  assign OUT_B  = rd_data[1];
  assign PEND_A = rd_pend[0];
  assign PEND_B = rd_pend[1];

endmodule
